// File: rtl/gui_pkg.sv
// Shared OLED geometry, transparency key and punch animation state type
// for the sprite compositors.
package gui_pkg;

   localparam int OLED_W      = 96;
   localparam int OLED_H      = 64;
   localparam int OLED_PIXELS = 6144;

   localparam logic [15:0] TRANSPARENT = 16'h0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WIND,
      ST_EXTEND,
      ST_STRIKE,
      ST_RECOVER
   } punch_state_t;

endpackage

// File: rtl/oled_pixel_xy.sv
// Splits a row-major 96x64 pixel index into row and column using a
// restoring compare/subtract chain; on_screen is low for indices >= 6144.
module oled_pixel_xy
   import gui_pkg::*;
(
   input  logic [12:0] pixel_index,
   output logic [5:0]  row,
   output logic [6:0]  col,
   output logic        on_screen
);

   logic [12:0] rem;

   // Each stage strips one 96<<k slice; whatever is left is the column.
   always_comb begin
      rem = pixel_index;
      row = '0;
      for (int k = 5; k >= 0; k--) begin
         if (rem >= 13'(OLED_W << k)) begin
            rem    = rem - 13'(OLED_W << k);
            row[k] = 1'b1;
         end
      end
      col       = rem[6:0];
      on_screen = (rem < 13'(OLED_W));
   end

endmodule

// File: rtl/punch_anim_compositor.sv
// Punch animation sequencer stepping on OLED frame boundaries, plus a
// two-stage shift/mirror sprite compositor keyed on black transparency.
module punch_anim_compositor
   import gui_pkg::*;
#(
   parameter int unsigned FRAMES_PER_STEP = 3,
   parameter int unsigned RECOVER_FRAMES  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_begin,
   input  logic        punch_req,
   input  logic [12:0] pixel_index,
   input  logic [15:0] bg_colour,
   input  logic [7:0]  x_offset,
   input  logic        facing_left,
   input  logic [15:0] rom_idle,
   input  logic [15:0] rom_p1,
   input  logic [15:0] rom_p2,
   input  logic [15:0] rom_p3,
   output logic [12:0] sprite_index,
   output logic [15:0] oled_colour,
   output logic        busy,
   output logic        hit_window
);

   punch_state_t state_q, state_d;
   logic         pending_q, pending_d;
   logic [7:0]   frame_cnt_q, frame_cnt_d;
   logic [7:0]   limit_m1;
   logic         hit_q, hit_d;
   logic [7:0]   x_sh_q, x_sh_d;
   logic         facing_sh_q, facing_sh_d;

   logic [5:0]   pix_row;
   logic [6:0]   pix_col;
   logic         pix_on;
   logic [8:0]   d_full;

   logic [5:0]   row_q, row_d;
   logic [6:0]   d_q, d_d;
   logic         in_range_q, in_range_d;
   logic [15:0]  bg_q, bg_d;
   logic [6:0]   src;
   logic [15:0]  rom_sel;
   logic [15:0]  colour_q, colour_d;

   oled_pixel_xy u_xy (
      .pixel_index (pixel_index),
      .row         (pix_row),
      .col         (pix_col),
      .on_screen   (pix_on)
   );

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      frame_cnt_d = frame_cnt_q;
      limit_m1    = (state_q == ST_RECOVER) ? 8'(RECOVER_FRAMES - 1)
                                            : 8'(FRAMES_PER_STEP - 1);
      case (state_q)
         ST_IDLE: begin
            if (frame_begin && (pending_q || punch_req)) begin
               state_d     = ST_WIND;
               pending_d   = 1'b0;
               frame_cnt_d = '0;
            end else if (punch_req) begin
               pending_d = 1'b1;
            end
         end
         default: begin
            if (frame_begin) begin
               if (frame_cnt_q == limit_m1) begin
                  frame_cnt_d = '0;
                  case (state_q)
                     ST_WIND:   state_d = ST_EXTEND;
                     ST_EXTEND: state_d = ST_STRIKE;
                     ST_STRIKE: state_d = ST_RECOVER;
                     default:   state_d = ST_IDLE;
                  endcase
               end else begin
                  frame_cnt_d = frame_cnt_q + 8'd1;
               end
            end
         end
      endcase
      hit_d = (state_d == ST_STRIKE);
   end

   always_comb begin
      x_sh_d      = frame_begin ? x_offset : x_sh_q;
      facing_sh_d = frame_begin ? facing_left : facing_sh_q;
   end

   // Only an in-range d (0..95) is ever consumed, so seven bits are kept.
   always_comb begin
      d_full     = {2'b00, pix_col} - {x_sh_q[7], x_sh_q};
      in_range_d = pix_on && !d_full[8] && (d_full[7:0] <= 8'(OLED_W - 1));
      d_d        = d_full[6:0];
      row_d      = pix_row;
      bg_d       = bg_colour;
   end

   always_comb begin
      src          = facing_sh_q ? (7'(OLED_W - 1) - d_q) : d_q;
      sprite_index = in_range_q ? (13'(row_q) * 13'(OLED_W) + 13'(src)) : '0;
      case (state_q)
         ST_WIND:    rom_sel = rom_p1;
         ST_EXTEND:  rom_sel = rom_p2;
         ST_STRIKE:  rom_sel = rom_p3;
         ST_RECOVER: rom_sel = rom_p1;
         default:    rom_sel = rom_idle;
      endcase
      colour_d = (in_range_q && (rom_sel != TRANSPARENT)) ? rom_sel : bg_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         pending_q   <= 1'b0;
         frame_cnt_q <= '0;
         hit_q       <= 1'b0;
         x_sh_q      <= '0;
         facing_sh_q <= 1'b0;
         row_q       <= '0;
         d_q         <= '0;
         in_range_q  <= 1'b0;
         bg_q        <= '0;
         colour_q    <= '0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         frame_cnt_q <= frame_cnt_d;
         hit_q       <= hit_d;
         x_sh_q      <= x_sh_d;
         facing_sh_q <= facing_sh_d;
         row_q       <= row_d;
         d_q         <= d_d;
         in_range_q  <= in_range_d;
         bg_q        <= bg_d;
         colour_q    <= colour_d;
      end
   end

   assign oled_colour = colour_q;
   assign hit_window  = hit_q;
   assign busy        = pending_q | (state_q != ST_IDLE);

endmodule

// File: tb/tb_punch_anim_compositor.sv
// Self-checking bench: behavioural frame-position model plus arithmetic
// addressing model, driven with directed cases and randomized pixel bursts.
module tb_punch_anim_compositor;

   localparam int FPS   = 3;
   localparam int REC   = 4;
   localparam int TOTAL = 3 * FPS + REC;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_begin;
   logic        punch_req;
   logic [12:0] pixel_index;
   logic [15:0] bg_colour;
   logic [7:0]  x_offset;
   logic        facing_left;
   logic [15:0] rom_idle, rom_p1, rom_p2, rom_p3;
   logic [12:0] sprite_index;
   logic [15:0] oled_colour;
   logic        busy;
   logic        hit_window;

   logic        rom_ovr_en  = 1'b0;
   logic [15:0] rom_ovr_val = 16'h0000;

   int checks   = 0;
   int failures = 0;

   int          m_pos;
   bit          m_pend;
   logic [7:0]  m_xo;
   bit          m_fl;

   always #5 clk = ~clk;

   punch_anim_compositor #(.FRAMES_PER_STEP(FPS), .RECOVER_FRAMES(REC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_begin  (frame_begin),
      .punch_req    (punch_req),
      .pixel_index  (pixel_index),
      .bg_colour    (bg_colour),
      .x_offset     (x_offset),
      .facing_left  (facing_left),
      .rom_idle     (rom_idle),
      .rom_p1       (rom_p1),
      .rom_p2       (rom_p2),
      .rom_p3       (rom_p3),
      .sprite_index (sprite_index),
      .oled_colour  (oled_colour),
      .busy         (busy),
      .hit_window   (hit_window)
   );

   function automatic logic [15:0] rom_fn(input logic [12:0] idx, input int k);
      int v;
      if ((int'(idx) + k) % 5 == 0) return 16'h0000;
      v = (int'(idx) * 37 + k * 1000) ^ 32'h0000A5A5;
      return 16'(v) | 16'h0001;
   endfunction

   assign rom_idle = rom_ovr_en ? rom_ovr_val : rom_fn(sprite_index, 0);
   assign rom_p1   = rom_ovr_en ? rom_ovr_val : rom_fn(sprite_index, 1);
   assign rom_p2   = rom_ovr_en ? rom_ovr_val : rom_fn(sprite_index, 2);
   assign rom_p3   = rom_ovr_en ? rom_ovr_val : rom_fn(sprite_index, 3);

   // Animation tracked as a single frame position: -1 idle, 0..TOTAL-1 running.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pos  <= -1;
         m_pend <= 1'b0;
         m_xo   <= '0;
         m_fl   <= 1'b0;
      end else begin
         if (frame_begin) begin
            m_xo <= x_offset;
            m_fl <= facing_left;
         end
         if (m_pos < 0) begin
            if (frame_begin && (m_pend || punch_req)) begin
               m_pos  <= 0;
               m_pend <= 1'b0;
            end else if (punch_req) begin
               m_pend <= 1'b1;
            end
         end else if (frame_begin) begin
            m_pos <= (m_pos + 1 == TOTAL) ? -1 : m_pos + 1;
         end
      end
   end

   function automatic int sel_of(input int pos);
      if (pos < 0) return 0;
      if (pos < 3 * FPS) return pos / FPS + 1;
      return 1;
   endfunction

   function automatic bit in_view(input int pix, input int xo);
      int d;
      if (pix >= 6144) return 1'b0;
      d = (pix % 96) - xo;
      return (d >= 0) && (d <= 95);
   endfunction

   function automatic int exp_index(input int pix, input int xo, input bit fl);
      int d;
      if (!in_view(pix, xo)) return 0;
      d = (pix % 96) - xo;
      return (pix / 96) * 96 + (fl ? 95 - d : d);
   endfunction

   function automatic logic [15:0] exp_colour(input int pix, input int xo, input bit fl,
                                              input logic [15:0] bg, input int sel);
      logic [15:0] rv;
      if (!in_view(pix, xo)) return bg;
      rv = rom_fn(13'(exp_index(pix, xo, fl)), sel);
      return (rv != 16'h0000) ? rv : bg;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input bit fb, input bit req);
      frame_begin = fb;
      punch_req   = req;
      @(posedge clk);
      #1;
      frame_begin = 1'b0;
      punch_req   = 1'b0;
   endtask

   task automatic set_shadow(input int xo, input bit fl);
      x_offset    = 8'(xo);
      facing_left = fl;
      applyStimulus(1'b1, 1'b0);
   endtask

   task automatic show_pixel(input int pix, input logic [15:0] bg);
      pixel_index = 13'(pix);
      bg_colour   = bg;
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int xo, pix, mode, c;
      bit fl;
      int h0, h1;
      logic [15:0] b0, b1, bg;
      int bxo[6];
      int bpix[6];

      rst_n       = 1'b0;
      frame_begin = 1'b0;
      punch_req   = 1'b0;
      pixel_index = '0;
      bg_colour   = '0;
      x_offset    = '0;
      facing_left = 1'b0;
      #12;
      checkOutput("reset_sprite_index", sprite_index, 0);
      checkOutput("reset_oled_colour", oled_colour, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_hit", hit_window, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Transparency keying on the idle sprite
      rom_ovr_en  = 1'b1;
      rom_ovr_val = 16'h0000;
      set_shadow(0, 1'b0);
      show_pixel(100, 16'hF800);
      checkOutput("transp_black_key", oled_colour, 16'hF800);
      rom_ovr_val = 16'hFFDF;
      show_pixel(100, 16'hF800);
      checkOutput("transp_opaque", oled_colour, 16'hFFDF);
      rom_ovr_en = 1'b0;

      // Addressing: mirror, shift out of range, shift in range
      set_shadow(0, 1'b1);
      show_pixel(1930, 16'h1234);
      checkOutput("addr_mirror", sprite_index, 2005);
      set_shadow(10, 1'b0);
      show_pixel(1925, 16'h4321);
      checkOutput("addr_left_out_idx", sprite_index, 0);
      checkOutput("addr_left_out_bg", oled_colour, 16'h4321);
      show_pixel(1935, 16'h4321);
      checkOutput("addr_shift_in", sprite_index, 1925);

      // Column boundaries d=-1, d=0, d=96, d=95 and off-screen indices
      bxo  = '{10, 10, -1, 0, 0, 0};
      bpix = '{1929, 1930, 95, 95, 6144, 8191};
      for (int i = 0; i < 6; i++) begin
         set_shadow(bxo[i], 1'b0);
         show_pixel(bpix[i], 16'h0F0F);
         checkOutput($sformatf("bound_idx_%0d", i), sprite_index, exp_index(bpix[i], bxo[i], 1'b0));
         checkOutput($sformatf("bound_col_%0d", i), oled_colour,
                     exp_colour(bpix[i], bxo[i], 1'b0, 16'h0F0F, 0));
      end

      // Shadowing: x_offset change takes effect only after a frame_begin
      set_shadow(0, 1'b0);
      show_pixel(1935, 16'h0000);
      x_offset = 8'd10;
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);
      checkOutput("shadow_hold", sprite_index, 1935);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("shadow_update", sprite_index, 1925);

      // Randomized pixel bursts with random shift and mirroring
      for (int b = 0; b < 30; b++) begin
         xo = int'($urandom_range(0, 191)) - 96;
         fl = 1'($urandom_range(0, 1));
         set_shadow(xo, fl);
         applyStimulus(1'b0, 1'b0);
         h0 = 0; h1 = 0; b0 = '0; b1 = '0;
         for (int i = 0; i < 24; i++) begin
            if (i >= 1) checkOutput("rand_index", sprite_index, exp_index(h0, xo, fl));
            if (i >= 2) checkOutput("rand_colour", oled_colour, exp_colour(h1, xo, fl, b1, 0));
            mode = int'($urandom_range(0, 9));
            if (mode == 0) begin
               pix = int'($urandom_range(6144, 8191));
            end else if (mode <= 3) begin
               case ($urandom_range(0, 3))
                  0: c = xo - 1;
                  1: c = xo;
                  2: c = xo + 95;
                  default: c = xo + 96;
               endcase
               if (c >= 0 && c <= 95) pix = int'($urandom_range(0, 63)) * 96 + c;
               else pix = int'($urandom_range(0, 6143));
            end else begin
               pix = int'($urandom_range(0, 6143));
            end
            bg = 16'($urandom);
            h1 = h0; b1 = b0;
            h0 = pix; b0 = bg;
            pixel_index = 13'(pix);
            bg_colour   = bg;
            applyStimulus(1'b0, 1'b0);
         end
      end

      // Full punch sequence at defaults, with an ignored request during STRIKE
      set_shadow(0, 1'b0);
      show_pixel(1, 16'h07E0);
      applyStimulus(1'b0, 1'b1);
      checkOutput("seq_busy_pending", busy, 1);
      checkOutput("seq_hit_pending", hit_window, 0);
      for (int p = 1; p <= 14; p++) begin
         applyStimulus(1'b1, 1'b0);
         if (p == 8) applyStimulus(1'b0, 1'b1);
         applyStimulus(1'b0, 1'b0);
         applyStimulus(1'b0, 1'b0);
         checkOutput($sformatf("seq_hit_p%0d", p), hit_window, (p >= 7 && p <= 9));
         checkOutput($sformatf("seq_busy_p%0d", p), busy, (p < 14));
         checkOutput($sformatf("seq_colour_p%0d", p), oled_colour,
                     exp_colour(1, 0, 1'b0, 16'h07E0, sel_of(m_pos)));
      end

      // Request coincident with frame_begin, then reset asserted mid-STRIKE
      applyStimulus(1'b1, 1'b1);
      checkOutput("simul_busy", busy, 1);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("simul_wind_colour", oled_colour, exp_colour(1, 0, 1'b0, 16'h07E0, 1));
      for (int p = 2; p <= 7; p++) applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("strike_hit", hit_window, 1);
      checkOutput("strike_colour", oled_colour, exp_colour(1, 0, 1'b0, 16'h07E0, 3));
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_colour", oled_colour, 0);
      checkOutput("async_rst_hit", hit_window, 0);
      checkOutput("async_rst_busy", busy, 0);
      checkOutput("async_rst_index", sprite_index, 0);
      applyStimulus(1'b0, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("post_rst_busy", busy, 0);
      checkOutput("post_rst_hit", hit_window, 0);
      checkOutput("post_rst_idle_colour", oled_colour, exp_colour(1, 0, 1'b0, 16'h07E0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/punch_anim_compositor.md
# punch_anim_compositor

Fighter punch animation sequencer and sprite compositor. It sits between the OLED pixel driver and the fighter sprite ROMs (idle, punch 1/2/3), which are combinational pixel_index → RGB565 lookups returning black for empty pixels. On a punch request it steps through the punch frames on OLED frame boundaries, shifts and optionally mirrors the sprite horizontally, and composites it over the background layer using black as the transparent key.

## Interface
- FRAMES_PER_STEP, 3: frame_begin pulses spent in each of WIND/EXTEND/STRIKE; must be ≥1
- RECOVER_FRAMES, 4: frame_begin pulses spent in RECOVER; must be ≥1
- clk  in  1  system clock; one clock for the whole block
- rst_n  in  1  asynchronous, active-low reset
- frame_begin  in  1  one-cycle pulse from the OLED driver at the start of each frame
- punch_req  in  1  punch trigger, pulse or level
- pixel_index  in  13  pixel currently requested by the OLED driver, 0..6143 (96×64, row-major)
- bg_colour  in  16  background RGB565, aligned with pixel_index
- x_offset  in  8  signed sprite horizontal displacement, −96..95
- facing_left  in  1  mirror the sprite horizontally
- rom_idle, rom_p1, rom_p2, rom_p3  in  16 each  sprite ROM outputs for sprite_index
- sprite_index  out  13  address driven to all four sprite ROMs
- oled_colour  out  16  composited RGB565 to the OLED driver
- busy  out  1  animation pending or running
- hit_window  out  1  high during STRIKE, consumed by hit detection

## Operation
- FSM states: IDLE, WIND, EXTEND, STRIKE, RECOVER. ROM shown: IDLE→rom_idle, WIND→rom_p1, EXTEND→rom_p2, STRIKE→rom_p3, RECOVER→rom_p1.
- In IDLE, a punch_req high in any cycle sets pending. State advances only on frame_begin cycles, so there is no mid-frame tearing.
- IDLE→WIND happens on frame_begin when pending or punch_req is high. A punch_req coinciding with frame_begin transitions on that same frame. Pending clears on the transition.
- frame_cnt counts frame_begin pulses within a state. When frame_begin arrives and frame_cnt = N−1, the block moves to the next state and clears frame_cnt. N is FRAMES_PER_STEP, or RECOVER_FRAMES in RECOVER. RECOVER→IDLE.
- punch_req outside IDLE is ignored and not queued.
- x_offset and facing_left are captured into shadow registers on every frame_begin. Only the shadow values are used for addressing.
- Addressing: row = pixel_index / 96, col = pixel_index mod 96. Division uses a compare/subtract chain, not a divider IP.
  - d = col − x_off (9-bit signed).
  - in_range = 0 ≤ d ≤ 95.
  - src = facing_left ? 95 − d : d.
  - sprite_index = row·96 + src when in_range, else 0.
- Composite: when in_range and the selected ROM value ≠ 16'h0000, output the ROM value; otherwise output bg_colour.
- busy = pending | (state ≠ IDLE). hit_window = (state == STRIKE), registered.

## Timing
- Stage 1 registers row, d, in_range and bg_colour. sprite_index is driven from the stage-1 registers, and the ROMs respond combinationally.
- Stage 2 registers oled_colour. Latency from pixel_index to oled_colour is exactly 2 cycles. The OLED driver accounts for this.
- Reset values:
  - state IDLE; pending 0; frame_cnt 0
  - shadow x_off 0; shadow facing 0
  - sprite_index 0; oled_colour 0
  - busy 0; hit_window 0
- Reset asserted mid-animation forces all of the above immediately, asynchronously. After release the block waits for a new punch_req.
- A full punch occupies 3·FRAMES_PER_STEP + RECOVER_FRAMES frames, which is 13 at the defaults. hit_window is high for FRAMES_PER_STEP frames.
- Boundaries:
  - pixel_index > 6143 is treated as out of range, so oled_colour = bg_colour.
  - d = −1 and d = 96 are out of range; d = 0 and d = 95 are in range.

## Structure
- Shared package gui_pkg holds:
  - OLED_W=96, OLED_H=64, OLED_PIXELS=6144
  - TRANSPARENT=16'h0000
  - the punch_state_t enum
- Sub-module oled_pixel_xy converts pixel_index to row and column (13-bit → 6-bit row, 7-bit col) and is reused by other compositors.

## Test plan
- Reset: assert rst_n=0 mid-STRIKE → oled_colour=0, hit_window=0, busy=0 with no clock edge; after release, frame_begin pulses without punch_req keep the state IDLE.
- Transparency: IDLE, x_offset=0, pixel_index=100, bg=16'hF800.
  - rom_idle=0 → oled_colour=16'hF800 after 2 cycles.
  - rom_idle=16'hFFDF → oled_colour=16'hFFDF.
- Sequence at defaults: one-cycle punch_req, then frame_begin pulses.
  - WIND on pulse 1, EXTEND on pulse 4, STRIKE on pulse 7 (hit_window high), RECOVER on pulse 10, IDLE on pulse 14.
  - busy is high from punch_req until pulse 14.
  - A punch_req during STRIKE changes nothing.
- Addressing:
  - facing_left=1, x_offset=0, pixel_index=1930 (row 20, col 10) → sprite_index=2005.
  - x_offset=10, col 5 → out of range, bg passthrough.
  - x_offset=10, col 15 → sprite_index=row·96+5.
- Shadowing: change x_offset mid-frame → sprite_index unchanged until the cycle after the next frame_begin.
- Simultaneous events: punch_req and frame_begin in the same cycle while IDLE → state is WIND on the next cycle.
